// File: rtl/cmsdk_apb4_eg_slave_ws.sv
// APB4 example slave: NUM_REGS read/write words plus a read-only ID word,
// programmable wait states, byte-strobe writes and PSLVERR on bad accesses.
module cmsdk_apb4_eg_slave_ws #(
    parameter int ADDRWIDTH   = 12,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0,
    parameter int PROT_CHECK  = 0
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 PSEL,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [31:0]          PWDATA,
    input  logic [3:0]           PSTRB,
    input  logic [2:0]           PPROT,
    input  logic [3:0]           ECOREVNUM,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR
);

    localparam int                  IDXW   = ADDRWIDTH - 2;
    localparam logic [IDXW-1:0]     ID_IDX = IDXW'(NUM_REGS);
    localparam logic [7:0]          NREG8  = 8'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic [IDXW-1:0]             idx_q, idx_d;
    logic [NUM_REGS-1:0][31:0]   regs;
    logic [IDXW-1:0]             idx;
    logic                        dec_err;
    logic                        complete;
    logic                        wr_en;
    logic [31:0]                 rd_word;
    logic                        unused_pprot;

    assign unused_pprot = ^PPROT[2:1];
    assign idx          = PADDR[ADDRWIDTH-1:2];

    // Only bit 0 of PPROT matters, and only for writes when checking is on.
    assign dec_err = (PADDR[1:0] != 2'b00) || (idx > ID_IDX) ||
                     (PWRITE && ((idx == ID_IDX) || (PROT_CHECK != 0 && !PPROT[0])));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    err_d = dec_err;
                    idx_d = idx;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                // Master abandoned the transfer: drop it without writing.
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = ACCESS;
                end
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign complete = (state_q == ACCESS) && PSEL && PENABLE;
    assign wr_en    = complete && PWRITE && !err_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            regs <= '0;
        end else if (wr_en) begin
            for (int r = 0; r < NUM_REGS; r++)
                for (int b = 0; b < 4; b++)
                    if (idx_q == IDXW'(r) && PSTRB[b])
                        regs[r][8*b +: 8] <= PWDATA[8*b +: 8];
        end
    end

    always_comb begin
        rd_word = (idx_q == ID_IDX) ? {ECOREVNUM, 20'h0, NREG8} : 32'h0;
        for (int r = 0; r < NUM_REGS; r++)
            if (idx_q == IDXW'(r)) rd_word = regs[r];
    end

    assign PREADY  = (state_q != WAIT);
    assign PSLVERR = complete && err_q;
    assign PRDATA  = (complete && !err_q && !PWRITE) ? rd_word : 32'h0;

endmodule

// File: tb/tb_cmsdk_apb4_eg_slave_ws.sv
// Directed bench for cmsdk_apb4_eg_slave_ws: three instances cover
// 3 wait states, zero wait states with protection check, and 15 wait states.
module tb_cmsdk_apb4_eg_slave_ws;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  psel;
    logic [11:0] paddr;
    logic        penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [3:0]  ecorevnum;
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    cmsdk_apb4_eg_slave_ws #(.ADDRWIDTH(12), .NUM_REGS(8), .WAIT_STATES(3), .PROT_CHECK(0)) dut_a (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PADDR(paddr), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .ECOREVNUM(ecorevnum),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    cmsdk_apb4_eg_slave_ws #(.ADDRWIDTH(12), .NUM_REGS(8), .WAIT_STATES(0), .PROT_CHECK(1)) dut_b (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PADDR(paddr), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .ECOREVNUM(ecorevnum),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    cmsdk_apb4_eg_slave_ws #(.ADDRWIDTH(12), .NUM_REGS(8), .WAIT_STATES(15), .PROT_CHECK(0)) dut_c (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PADDR(paddr), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .ECOREVNUM(ecorevnum),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Setup + access phases; returns after sampling the completion cycle so a
    // following call starts its setup immediately (no bubble).
    task automatic xfer(input int d, input logic wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                        output logic [31:0] rd, output logic err, output int cyc);
        @(posedge clk); #1;
        psel = '0; psel[d] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = wd; pstrb = st; pprot = pr;
        cyc = 1; rd = '0; err = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            if (pready[d]) begin
                rd  = prdata[d];
                err = pslverr[d];
                return;
            end
            @(posedge clk); #1;
        end
        n_vec++;
        n_err++;
        $display("FAIL timeout: PREADY never rose on dut %0d", d);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel = '0; penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cy;

        psel = '0; paddr = '0; penable = 1'b0; pwrite = 1'b0;
        pwdata = '0; pstrb = '0; pprot = '0; ecorevnum = 4'hA;
        #1;
        check("rst_pready_a", 32'(pready[0]), 1);
        check("rst_pready_c", 32'(pready[2]), 1);
        check("rst_pslverr_a", 32'(pslverr[0]), 0);
        check("rst_prdata_a", prdata[0], 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Every word reads zero after reset, 5-cycle transfers with 3 wait states.
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b0, 12'(4*i), 0, 4'hF, 3'b000, rd, er, cy);
            check($sformatf("rst_rd_%0d", i), rd, 0);
            check($sformatf("rst_err_%0d", i), 32'(er), 0);
        end
        check("rd_cycles_ws3", 32'(cy), 5);
        idle();

        xfer(0, 1'b1, 12'h004, 32'h12345678, 4'b0101, 3'b000, rd, er, cy);
        check("strb_wr_err", 32'(er), 0);
        check("strb_wr_cycles", 32'(cy), 5);
        xfer(0, 1'b0, 12'h004, 0, 4'h0, 3'b000, rd, er, cy);
        check("strb_rd", rd, 32'h00340078);
        check("strb_rd_cycles", 32'(cy), 5);
        idle();
        #1 check("idle_prdata", prdata[0], 0);

        xfer(0, 1'b1, 12'h004, 32'hFFFFFFFF, 4'b0000, 3'b000, rd, er, cy);
        check("strb0_err", 32'(er), 0);
        xfer(0, 1'b0, 12'h004, 0, 4'hF, 3'b000, rd, er, cy);
        check("strb0_rd", rd, 32'h00340078);

        xfer(0, 1'b0, 12'h020, 0, 4'hF, 3'b000, rd, er, cy);
        check("id_rd", rd, 32'hA0000008);
        check("id_err", 32'(er), 0);

        xfer(0, 1'b1, 12'h020, 32'h55555555, 4'hF, 3'b000, rd, er, cy);
        check("id_wr_err", 32'(er), 1);
        xfer(0, 1'b0, 12'h020, 0, 4'hF, 3'b000, rd, er, cy);
        check("id_after_wr", rd, 32'hA0000008);

        xfer(0, 1'b0, 12'h024, 0, 4'hF, 3'b000, rd, er, cy);
        check("oob_err", 32'(er), 1);
        check("oob_rd", rd, 0);

        xfer(0, 1'b1, 12'h006, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, cy);
        check("misal_wr_err", 32'(er), 1);
        xfer(0, 1'b0, 12'h006, 0, 4'hF, 3'b000, rd, er, cy);
        check("misal_rd_err", 32'(er), 1);
        check("misal_rd_data", rd, 0);
        xfer(0, 1'b0, 12'h004, 0, 4'hF, 3'b000, rd, er, cy);
        check("misal_keep4", rd, 32'h00340078);
        xfer(0, 1'b0, 12'h000, 0, 4'hF, 3'b000, rd, er, cy);
        check("misal_keep0", rd, 0);
        idle();

        // Protection check, zero wait states.
        xfer(1, 1'b1, 12'h000, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, cy);
        check("prot0_err", 32'(er), 1);
        check("prot0_cycles", 32'(cy), 2);
        xfer(1, 1'b0, 12'h000, 0, 4'hF, 3'b000, rd, er, cy);
        check("prot0_rd", rd, 0);
        check("prot0_rd_err", 32'(er), 0);
        xfer(1, 1'b1, 12'h000, 32'hFFFFFFFF, 4'hF, 3'b001, rd, er, cy);
        check("prot1_err", 32'(er), 0);
        xfer(1, 1'b0, 12'h000, 0, 4'hF, 3'b000, rd, er, cy);
        check("prot1_rd", rd, 32'hFFFFFFFF);
        idle();

        // 15 wait states, back-to-back write then read.
        xfer(2, 1'b1, 12'h01C, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, cy);
        check("ws15_wr_cycles", 32'(cy), 17);
        xfer(2, 1'b0, 12'h01C, 0, 4'hF, 3'b000, rd, er, cy);
        check("ws15_rd_cycles", 32'(cy), 17);
        check("ws15_rd", rd, 32'hCAFEF00D);
        idle();

        // Reset in the middle of a WAIT phase.
        @(posedge clk); #1;
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 12'h01C;
        pwdata = 32'h11111111; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("wait_pready_low", 32'(pready[2]), 0);
        rst_n = 1'b0;
        #1 check("rst_mid_pready", 32'(pready[2]), 1);
        psel = '0; penable = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        xfer(2, 1'b0, 12'h01C, 0, 4'hF, 3'b000, rd, er, cy);
        check("rst_mid_rd", rd, 0);
        check("rst_mid_err", 32'(er), 0);
        xfer(0, 1'b0, 12'h004, 0, 4'hF, 3'b000, rd, er, cy);
        check("rst_mid_rd_a", rd, 0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
